// File: rtl/qsort_pkg.sv
// qsort_pkg: definitions shared by the quicksort controller, the partition
// engine and the element-RAM arbiter.
//   owner_t     - RAM ownership / arbiter state (OWN_NONE doubles as IDLE)
//   QS_AW/QS_DW - default element address / data widths
//   QS_MAX_LOCK - default watchdog limit on consecutive locked cycles
//   SIDE_H/P    - encoding of the round-robin pointer and read owner
package qsort_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_H    = 2'd1,
    OWN_P    = 2'd2
  } owner_t;

  localparam int QS_AW       = 8;
  localparam int QS_DW       = 32;
  localparam int QS_MAX_LOCK = 8;

  localparam logic SIDE_H = 1'b0;
  localparam logic SIDE_P = 1'b1;

endpackage

// File: rtl/qsort_arb_rr2.sv
// qsort_arb_rr2: two-way round-robin picker.
// Ports:
//   req[1:0] in  - bit 0 = host, bit 1 = partition engine
//   ptr      in  - preferred side when both request (0 = host, 1 = engine)
//   gnt[1:0] out - one-hot (or zero) grant, never set without its req
module qsort_arb_rr2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | ~ptr);
    gnt[1] = req[1] & (~req[0] |  ptr);
  end

endmodule

// File: rtl/qsort_mem_arbiter.sv
// qsort_mem_arbiter: shares one single-port element RAM between the host
// port (H) and the partition engine (P). Round-robin arbitration; a side may
// lock the RAM for a burst (e.g. read/read/write/write swap) and a watchdog
// breaks a lock after MAX_LOCK consecutive owned cycles.
//
// Handshake: an access is accepted in any cycle where x_req && x_gnt. x_gnt
// is combinational; the accepted access is driven onto the RAM port in the
// same cycle. A read's data returns on rdata the next cycle, flagged by a
// one-cycle x_rvalid. A requester holds req/we/addr/wdata/lock stable until
// it sees gnt.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   h_req/h_we/h_addr/h_wdata/h_lock host request side
//   h_gnt, h_rvalid                 host grant, read-data valid
//   p_*                             same for the partition engine
//   rdata                           read data (straight from mem_rdata)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  RAM port
//   lock_timeout                    one-cycle pulse after a lock is broken
//   dbg_state, dbg_rr_ptr           FSM state and round-robin pointer
// Optional (macro QSORT_ARB_STATS_EN):
//   h_grant_cnt, p_grant_cnt, conflict_cnt  saturating 16-bit counters
module qsort_mem_arbiter
  import qsort_pkg::*;
#(
  parameter int AW       = QS_AW,
  parameter int DW       = QS_DW,
  parameter int MAX_LOCK = QS_MAX_LOCK
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  input  logic          h_lock,
  output logic          h_gnt,
  output logic          h_rvalid,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  input  logic          p_lock,
  output logic          p_gnt,
  output logic          p_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_timeout,
`ifdef QSORT_ARB_STATS_EN
  output logic [15:0]   h_grant_cnt,
  output logic [15:0]   p_grant_cnt,
  output logic [15:0]   conflict_cnt,
`endif
  output logic [1:0]    dbg_state,
  output logic          dbg_rr_ptr
);

  localparam int HW = $clog2(MAX_LOCK + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_LOCK);
  // hold_cnt counts owned cycles already completed, so the current cycle is
  // number hold_cnt+1; the last permitted one is where hold_cnt == MAX_LOCK-1.
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_LOCK - 1);

  owner_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_d;
  logic          rd_valid_q;
  logic          rd_owner_q;
  logic [1:0]    rr_gnt;
  logic          own_req, own_lock, own_side;

  qsort_arb_rr2 u_rr (
    .req ({p_req, h_req}),
    .ptr (rr_q),
    .gnt (rr_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OWN_NONE;
      rr_q         <= SIDE_H;
      hold_q       <= '0;
      lock_timeout <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= SIDE_H;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      hold_q       <= hold_d;
      lock_timeout <= timeout_d;
      rd_valid_q   <= mem_en & ~mem_we;
      if (mem_en & ~mem_we) rd_owner_q <= p_gnt;
    end
  end

  always_comb begin
    h_gnt     = 1'b0;
    p_gnt     = 1'b0;
    state_d   = state_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    own_side  = (state_q == OWN_P);
    own_req   = own_side ? p_req  : h_req;
    own_lock  = own_side ? p_lock : h_lock;

    case (state_q)
      OWN_H:   h_gnt = h_req;
      OWN_P:   p_gnt = p_req;
      default: {p_gnt, h_gnt} = rr_gnt;
    endcase

    case (state_q)
      OWN_H, OWN_P: begin
        if (own_req && own_lock && hold_q < HOLD_LAST) begin
          hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end else begin
          // Normal release, idle owner, or watchdog break: all hand
          // priority to the other side.
          state_d   = OWN_NONE;
          hold_d    = '0;
          rr_d      = ~own_side;
          timeout_d = own_req & own_lock;
        end
      end
      default: begin
        if (h_gnt || p_gnt) begin
          if ((h_gnt ? h_lock : p_lock) && MAX_LOCK > 1) begin
            state_d = h_gnt ? OWN_H : OWN_P;
            hold_d  = HW'(1);
          end else begin
            rr_d      = h_gnt ? SIDE_P : SIDE_H;
            // With MAX_LOCK == 1 a locked access is already the last one.
            timeout_d = h_gnt ? h_lock : p_lock;
          end
        end
      end
    endcase
  end

  always_comb begin
    mem_en    = h_gnt | p_gnt;
    mem_we    = p_gnt ? p_we    : (h_gnt & h_we);
    mem_addr  = p_gnt ? p_addr  : h_addr;
    mem_wdata = p_gnt ? p_wdata : h_wdata;
  end

  assign rdata      = mem_rdata;
  assign h_rvalid   = rd_valid_q & (rd_owner_q == SIDE_H);
  assign p_rvalid   = rd_valid_q & (rd_owner_q == SIDE_P);
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_q;

`ifdef QSORT_ARB_STATS_EN
  // Only one side can be granted, so both req high always means one denied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_grant_cnt  <= '0;
      p_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (h_gnt && h_grant_cnt != 16'hFFFF) h_grant_cnt <= h_grant_cnt + 16'd1;
      if (p_gnt && p_grant_cnt != 16'hFFFF) p_grant_cnt <= p_grant_cnt + 16'd1;
      if (h_req && p_req && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qsort_mem_arbiter.sv
// tb_qsort_mem_arbiter: directed checks of the element-RAM arbiter with a
// small behavioural RAM behind it.
module tb_qsort_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          h_req, h_we, h_lock, p_req, p_we, p_lock;
  logic [AW-1:0] h_addr, p_addr;
  logic [DW-1:0] h_wdata, p_wdata;
  logic          h_gnt, h_rvalid, p_gnt, p_rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, lock_timeout;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;
  logic          dbg_rr_ptr;
`ifdef QSORT_ARB_STATS_EN
  logic [15:0]   h_grant_cnt, p_grant_cnt, conflict_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- RAM model ----------------
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  qsort_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_lock(p_lock), .p_gnt(p_gnt), .p_rvalid(p_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lock_timeout(lock_timeout),
`ifdef QSORT_ARB_STATS_EN
    .h_grant_cnt(h_grant_cnt), .p_grant_cnt(p_grant_cnt),
    .conflict_cnt(conflict_cnt),
`endif
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0; h_lock = 0;
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0; p_lock = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    next_cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    vec_cnt++;
    if ({h_rvalid, p_rvalid, lock_timeout, mem_en} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {h_rvalid, p_rvalid, lock_timeout, mem_en});
    end
    vec_cnt++;
    if (dbg_state !== 2'd0 || dbg_rr_ptr !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: state=%0d rr=%0d expected 0/0", dbg_state, dbg_rr_ptr);
    end
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_host_rw();
    do_reset();
    h_req = 1; h_we = 1; h_addr = 8'h05; h_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vec_cnt++;
    if (h_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h05 ||
        mem_wdata !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL host_write: gnt=%b en=%b we=%b addr=%h wd=%h expected 1 1 1 05 deadbeef",
               h_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    h_we = 0;
    @(negedge clk);
    vec_cnt++;
    if (h_gnt !== 1'b1 || mem_we !== 1'b0 || h_rvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL host_read_issue: gnt=%b we=%b rvalid=%b expected 1 0 0",
               h_gnt, mem_we, h_rvalid);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    vec_cnt++;
    if (h_rvalid !== 1'b1 || p_rvalid !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL host_read_data: h_rv=%b p_rv=%b rdata=%h expected 1 0 deadbeef",
               h_rvalid, p_rvalid, rdata);
    end
    next_cycle();
    @(negedge clk);
    vec_cnt++;
    if (h_rvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL host_rvalid_once: got %b expected 0", h_rvalid);
    end
  endtask

  task automatic test_alternate();
    logic exp_h;
    do_reset();
    h_req = 1; h_addr = 8'h10; p_req = 1; p_addr = 8'h20;
    for (int i = 0; i < 6; i++) begin
      exp_h = (i % 2 == 0);
      @(negedge clk);
      vec_cnt++;
      if (h_gnt !== exp_h || p_gnt !== !exp_h ||
          mem_addr !== (exp_h ? 8'h10 : 8'h20)) begin
        err_cnt++;
        $display("FAIL alternate_grant[%0d]: h=%b p=%b addr=%h expected h=%b p=%b addr=%h",
                 i, h_gnt, p_gnt, mem_addr, exp_h, !exp_h, exp_h ? 8'h10 : 8'h20);
      end
      if (i > 0) begin
        vec_cnt++;
        if (h_rvalid !== !exp_h || p_rvalid !== exp_h) begin
          err_cnt++;
          $display("FAIL alternate_rvalid[%0d]: h_rv=%b p_rv=%b expected %b %b",
                   i, h_rvalid, p_rvalid, !exp_h, exp_h);
        end
      end
      next_cycle();
    end
    clear_inputs();
`ifdef QSORT_ARB_STATS_EN
    @(negedge clk);
    vec_cnt++;
    if (h_grant_cnt !== 16'd3 || p_grant_cnt !== 16'd3 || conflict_cnt !== 16'd6) begin
      err_cnt++;
      $display("FAIL stats_counts: h=%0d p=%0d c=%0d expected 3 3 6",
               h_grant_cnt, p_grant_cnt, conflict_cnt);
    end
    next_cycle();
`endif
  endtask

  task automatic test_swap_lock();
    logic lock_seq [4];
    lock_seq[0] = 1; lock_seq[1] = 1; lock_seq[2] = 1; lock_seq[3] = 0;
    do_reset();
    // One host access first so the pointer favours the engine.
    h_req = 1; h_we = 1; h_addr = 8'h01;
    @(negedge clk);
    vec_cnt++;
    if (h_gnt !== 1'b1) begin
      err_cnt++;
      $display("FAIL swap_prime: h_gnt=%b expected 1", h_gnt);
    end
    next_cycle();
    p_req = 1; p_addr = 8'h30;
    for (int i = 0; i < 4; i++) begin
      p_lock = lock_seq[i];
      p_we = (i >= 2);
      @(negedge clk);
      vec_cnt++;
      if (p_gnt !== 1'b1 || h_gnt !== 1'b0 || lock_timeout !== 1'b0) begin
        err_cnt++;
        $display("FAIL swap_cycle[%0d]: p=%b h=%b to=%b expected 1 0 0",
                 i, p_gnt, h_gnt, lock_timeout);
      end
      next_cycle();
    end
    p_req = 0; p_lock = 0;
    @(negedge clk);
    vec_cnt++;
    if (h_gnt !== 1'b1 || lock_timeout !== 1'b0) begin
      err_cnt++;
      $display("FAIL swap_release: h_gnt=%b to=%b expected 1 0", h_gnt, lock_timeout);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    h_req = 1; h_we = 1; h_addr = 8'h02;
    next_cycle();
    p_req = 1; p_lock = 1; p_addr = 8'h40;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (p_gnt !== 1'b1 || h_gnt !== 1'b0 || lock_timeout !== 1'b0) begin
        err_cnt++;
        $display("FAIL watchdog_hold[%0d]: p=%b h=%b to=%b expected 1 0 0",
                 i, p_gnt, h_gnt, lock_timeout);
      end
      next_cycle();
    end
    @(negedge clk);
    vec_cnt++;
    if (h_gnt !== 1'b1 || p_gnt !== 1'b0 || lock_timeout !== 1'b1) begin
      err_cnt++;
      $display("FAIL watchdog_break: h=%b p=%b to=%b expected 1 0 1",
               h_gnt, p_gnt, lock_timeout);
    end
    next_cycle();
    @(negedge clk);
    vec_cnt++;
    if (p_gnt !== 1'b1 || lock_timeout !== 1'b0) begin
      err_cnt++;
      $display("FAIL watchdog_pulse_once: p=%b to=%b expected 1 0", p_gnt, lock_timeout);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    h_req = 1; h_we = 1; h_addr = 8'h06; h_wdata = 32'h1234_5678;
    next_cycle();
    h_we = 0; h_addr = 8'h05;
    next_cycle();
    clear_inputs();
    vec_cnt++;
    if (h_rvalid !== 1'b1 || dbg_rr_ptr !== 1'b1) begin
      err_cnt++;
      $display("FAIL midreset_pre: h_rv=%b rr=%b expected 1 1", h_rvalid, dbg_rr_ptr);
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    vec_cnt++;
    if (h_rvalid !== 1'b0 || dbg_state !== 2'd0 || dbg_rr_ptr !== 1'b0) begin
      err_cnt++;
      $display("FAIL midreset_clear: h_rv=%b state=%0d rr=%b expected 0 0 0",
               h_rvalid, dbg_state, dbg_rr_ptr);
    end
    next_cycle();
    rst_n = 1;
    h_req = 1; p_req = 1;
    @(negedge clk);
    vec_cnt++;
    if (h_gnt !== 1'b1 || p_gnt !== 1'b0) begin
      err_cnt++;
      $display("FAIL midreset_first_grant: h=%b p=%b expected 1 0", h_gnt, p_gnt);
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_host_rw();
    test_alternate();
    test_swap_lock();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
